// File: rtl/text_case_pkg.sv
// Shared definitions for the to_lower_stream block.
//   state_t  : packet FSM states (IDLE / BUSY / DRAIN)
//   UPPER_LO : first ASCII upper-case letter ('A')
//   UPPER_HI : last ASCII upper-case letter ('Z')
//   CASE_BIT : bit that turns an upper-case letter into lower case
//   COUNT_MAX: saturation value of the converted-letter counter
package text_case_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,  // no packet open
        BUSY  = 2'd1,  // packet open, last byte not yet accepted
        DRAIN = 2'd2   // last byte accepted, waiting for it to leave
    } state_t;

    localparam logic [7:0]  UPPER_LO  = 8'h41;
    localparam logic [7:0]  UPPER_HI  = 8'h5A;
    localparam logic [7:0]  CASE_BIT  = 8'h20;
    localparam logic [15:0] COUNT_MAX = 16'hFFFF;

endpackage

// File: rtl/lower_map.sv
// Combinational ASCII upper-to-lower case mapping.
//   raw      : input byte
//   mapped   : raw with CASE_BIT set when raw is 'A'..'Z', else raw unchanged
//   is_upper : raw is an upper-case ASCII letter
// Bytes 0x80-0xFF are never treated as letters.
module lower_map
    import text_case_pkg::*;
(
    input  logic [7:0] raw,
    output logic [7:0] mapped,
    output logic       is_upper
);

    always_comb begin
        is_upper = (raw >= UPPER_LO) && (raw <= UPPER_HI);
        mapped   = is_upper ? (raw | CASE_BIT) : raw;
    end

endmodule

// File: rtl/to_lower_stream.sv
// Streaming lower-case converter with a small output buffer and packet tracking.
//   clk, rst                      : clock, synchronous active-high reset
//   in_valid/in_data/in_last      : input byte stream, in_ready = accept this cycle
//   out_valid/out_data/out_last   : mapped byte stream, out_ready = downstream accepts
//   done                          : one-cycle pulse after a packet's last byte left
//   done_count                    : letters converted in the packet just finished
//   fsm_state                     : current packet FSM state (debug/observation)
// DEPTH sets the buffer size; only 2 and 4 are supported (pointers wrap
// naturally because DEPTH is a power of two).
//
// Handshake: a transfer happens on a rising edge where valid && ready are both
// high; the source holds valid/data/last stable until it is taken, and ready
// never depends combinationally on the opposite side's valid or ready.
module to_lower_stream
    import text_case_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    input  logic [7:0]  in_data,
    input  logic        in_last,
    output logic        in_ready,
    output logic        out_valid,
    output logic [7:0]  out_data,
    output logic        out_last,
    input  logic        out_ready,
    output logic        done,
    output logic [15:0] done_count,
    output state_t      fsm_state
);

    localparam int PTR_W = (DEPTH == 4) ? 2 : 1;
    localparam int CNT_W = PTR_W + 1;

    // Each entry holds {last, mapped byte}.
    logic [8:0]       mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] fill;

    state_t      state_q;
    state_t      state_d;
    logic [15:0] letter_cnt;

    logic [7:0] mapped;
    logic       is_upper;
    logic       push;
    logic       pop;
    logic       pkt_end;

    lower_map u_map (
        .raw      (in_data),
        .mapped   (mapped),
        .is_upper (is_upper)
    );

    // in_ready looks only at registered state and rst, never at out_ready,
    // so a full buffer refuses a push even when it is being popped.
    always_comb begin
        in_ready  = !rst && (state_q != DRAIN) && (fill < CNT_W'(DEPTH));
        out_valid = (fill != '0);
        push      = in_valid && in_ready;
        pop       = out_valid && out_ready;
        {out_last, out_data} = out_valid ? mem[rd_ptr] : 9'h000;
        pkt_end   = pop && out_last;
        fsm_state = state_q;
    end

    // Buffer storage needs no reset: entries are only visible while fill > 0.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= {in_last, mapped};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            fill   <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   fill <= fill + CNT_W'(1);
                2'b01:   fill <= fill - CNT_W'(1);
                default: fill <= fill;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (push) begin
                    state_d = in_last ? DRAIN : BUSY;
                end
            end
            BUSY: begin
                if (push && in_last) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (pkt_end) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Letters are counted at acceptance. No byte is accepted in DRAIN, so when
    // the last byte leaves the counter already holds the packet's final total.
    always_ff @(posedge clk) begin
        if (rst) begin
            letter_cnt <= '0;
            done       <= 1'b0;
            done_count <= '0;
        end else begin
            done <= pkt_end;
            if (pkt_end) begin
                done_count <= letter_cnt;
            end
            if (state_d == IDLE) begin
                letter_cnt <= '0;
            end else if (push && is_upper && (letter_cnt != COUNT_MAX)) begin
                letter_cnt <= letter_cnt + 16'd1;
            end
        end
    end

endmodule

// File: tb/tb_to_lower_stream.sv
module tb_to_lower_stream;
    import text_case_pkg::*;

    localparam int DEPTH = 2;

    typedef logic [7:0] bq_t[$];
    typedef logic [8:0] eq_t[$];

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic [7:0]  in_data = 8'h00;
    logic        in_last = 1'b0;
    logic        in_ready;
    logic        out_valid;
    logic [7:0]  out_data;
    logic        out_last;
    logic        out_ready = 1'b0;
    logic        done;
    logic [15:0] done_count;
    state_t      fsm_state;

    int tests = 0;
    int fails = 0;

    // Behavioural model state.
    logic [8:0]  exp_q[$];      // {last, expected byte} in output order
    logic [15:0] pkt_cnt_q[$];  // expected done_count per closed packet
    logic [8:0]  got_q[$];      // bytes actually delivered, for literal checks
    logic [15:0] done_log[$];   // done_count seen at each expected done
    int          letters = 0;
    bit          pkt_closed = 0;
    bit          done_exp = 0;
    logic [15:0] dc_exp = 16'h0000;
    int          acc_total = 0;
    bit          mon_en = 0;

    to_lower_stream #(.DEPTH(DEPTH)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_data    (in_data),
        .in_last    (in_last),
        .in_ready   (in_ready),
        .out_valid  (out_valid),
        .out_data   (out_data),
        .out_last   (out_last),
        .out_ready  (out_ready),
        .done       (done),
        .done_count (done_count),
        .fsm_state  (fsm_state)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [7:0] ref_lower(input logic [7:0] b);
        if (b >= 8'd65 && b <= 8'd90) return b + 8'd32;
        return b;
    endfunction

    // ---------------- model + compare (mid-cycle, outputs settled) ----------------
    always @(negedge clk) begin
        if (mon_en) begin
            chk("in_ready", {31'd0, in_ready},
                {31'd0, !rst && (exp_q.size() < DEPTH) && !pkt_closed});
            chk("out_valid", {31'd0, out_valid}, {31'd0, exp_q.size() != 0});
            if (out_valid && exp_q.size() != 0)
                chk("out_byte", {23'd0, out_last, out_data}, {23'd0, exp_q[0]});
            chk("done", {31'd0, done}, {31'd0, done_exp});
            chk("done_count", {16'd0, done_count}, {16'd0, dc_exp});
            done_exp = 0;
            if (rst) begin
                exp_q.delete();
                pkt_cnt_q.delete();
                letters = 0;
                pkt_closed = 0;
                dc_exp = 16'h0000;
            end else begin
                if (out_valid && out_ready && exp_q.size() != 0) begin
                    logic [8:0] e;
                    e = exp_q.pop_front();
                    got_q.push_back(e);
                    if (e[8]) begin
                        done_exp = 1;
                        pkt_closed = 0;
                        if (pkt_cnt_q.size() != 0) dc_exp = pkt_cnt_q.pop_front();
                        done_log.push_back(dc_exp);
                    end
                end
                if (in_valid && in_ready) begin
                    acc_total++;
                    exp_q.push_back({in_last, ref_lower(in_data)});
                    if (in_data >= 8'd65 && in_data <= 8'd90 && letters < 65535) letters++;
                    if (in_last) begin
                        pkt_cnt_q.push_back(16'(letters));
                        letters = 0;
                        pkt_closed = 1;
                    end
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic send(input bq_t b, input bit close);
        for (int i = 0; i < b.size(); i++) begin
            int  waited = 0;
            bit  acc = 0;
            in_valid = 1'b1;
            in_data  = b[i];
            in_last  = close && (i == b.size() - 1);
            while (!acc) begin
                @(negedge clk);
                acc = in_ready;
                @(posedge clk);
                #1;
                waited++;
                if (!acc && waited > 200) begin
                    chk("send_timeout", 32'd1, 32'd0);
                    in_valid = 1'b0;
                    in_last  = 1'b0;
                    return;
                end
            end
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        while (exp_q.size() != 0 || pkt_closed || done_exp) begin
            @(posedge clk);
            #1;
            n++;
            if (n > 300) begin
                chk("idle_timeout", 32'd1, 32'd0);
                return;
            end
        end
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic chk_got(input string name, input eq_t exp);
        chk({name, "_len"}, got_q.size(), exp.size());
        for (int i = 0; i < exp.size() && i < got_q.size(); i++)
            chk(name, {23'd0, got_q[i]}, {23'd0, exp[i]});
    endtask

    task automatic chk_last_done(input string name, input logic [15:0] exp);
        if (done_log.size() == 0) chk({name, "_missing"}, 32'd0, 32'd1);
        else chk(name, {16'd0, done_log[done_log.size()-1]}, {16'd0, exp});
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        bq_t big;

        // Reset state while rst is held high.
        repeat (3) @(posedge clk);
        @(negedge clk);
        mon_en = 1;
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_in_ready", {31'd0, in_ready}, 32'd0);
        chk("rst_out_data", {23'd0, out_last, out_data}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_done_count", {16'd0, done_count}, 32'd0);
        chk("rst_state", {30'd0, fsm_state}, {30'd0, IDLE});
        @(posedge clk);
        #1 rst = 1'b0;

        // "Hi!"
        out_ready = 1'b1;
        got_q.delete();
        send('{8'h48, 8'h69, 8'h21}, 1);
        wait_idle();
        chk_got("hi", '{9'h068, 9'h069, 9'h121});
        chk_last_done("hi_done_count", 16'd1);

        // Letter-range boundaries and a high-half byte.
        got_q.delete();
        send('{8'h40, 8'h41, 8'h5A, 8'h5B, 8'hC1}, 1);
        wait_idle();
        chk_got("bound", '{9'h040, 9'h061, 9'h07A, 9'h05B, 9'h1C1});
        chk_last_done("bound_done_count", 16'd2);

        // Backpressure: downstream stalled for 10 cycles.
        got_q.delete();
        out_ready = 1'b0;
        fork
            begin
                int acc0;
                acc0 = acc_total;
                repeat (10) @(posedge clk);
                #2;
                chk("bp_accepts", acc_total - acc0, DEPTH);
                chk("bp_in_ready", {31'd0, in_ready}, 32'd0);
                out_ready = 1'b1;
            end
            send('{8'h41, 8'h62, 8'h43, 8'h64, 8'h45, 8'h21}, 1);
        join
        wait_idle();
        chk_got("bp", '{9'h061, 9'h062, 9'h063, 9'h064, 9'h065, 9'h121});
        chk_last_done("bp_done_count", 16'd3);

        // Single-byte packet held in DRAIN until popped.
        got_q.delete();
        out_ready = 1'b0;
        fork
            begin
                repeat (4) @(posedge clk);
                #2;
                chk("single_state", {30'd0, fsm_state}, {30'd0, DRAIN});
                chk("single_in_ready", {31'd0, in_ready}, 32'd0);
                out_ready = 1'b1;
            end
            send('{8'h5A}, 1);
        join
        wait_idle();
        chk_got("single", '{9'h17A});
        chk_last_done("single_done_count", 16'd1);

        // Reset after 2 of 4 bytes accepted.
        out_ready = 1'b0;
        send('{8'h57, 8'h58}, 0);
        @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("midrst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("midrst_state", {30'd0, fsm_state}, {30'd0, IDLE});
        @(posedge clk);
        #1;
        got_q.delete();
        out_ready = 1'b1;
        send('{8'h41, 8'h42}, 1);
        wait_idle();
        chk_got("ab", '{9'h061, 9'h162});
        chk_last_done("ab_done_count", 16'd2);

        // Long packet: letter counter saturates.
        got_q.delete();
        for (int i = 0; i < 70000; i++) big.push_back(8'h41);
        send(big, 1);
        wait_idle();
        chk("long_len", got_q.size(), 70000);
        if (got_q.size() != 0) chk("long_tail", {23'd0, got_q[got_q.size()-1]}, 32'h161);
        chk_last_done("long_done_count", 16'hFFFF);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
